// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pkg
// Brief  : Shared mode encodings, initial patterns and 27 MHz timing defaults
// Rev    : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int NUM_LEDS           = 6;
  localparam int DEFAULT_STEP_DIV   = 6_750_000;
  localparam int DEFAULT_DEB_CYCLES = 270_000;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef logic [NUM_LEDS-1:0] pattern_t;

  localparam pattern_t INIT_SHIFT  = 6'b000001;
  localparam pattern_t INIT_BOUNCE = 6'b000001;
  localparam pattern_t INIT_FILL   = 6'b000000;
  localparam pattern_t INIT_BLINK  = 6'b000000;

  function automatic pattern_t init_pattern(input mode_e m);
    pattern_t p;
    p = INIT_SHIFT;
    case (m)
      MODE_SHIFT:  p = INIT_SHIFT;
      MODE_BOUNCE: p = INIT_BOUNCE;
      MODE_FILL:   p = INIT_FILL;
      MODE_BLINK:  p = INIT_BLINK;
      default:     p = INIT_SHIFT;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Synchronize an active-low button, debounce it, pulse on accepted press
// Rev    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Counter only tracks an unbroken run of disagreement with the accepted level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : led_mode_sequencer
// Brief  : Four-mode 6-LED pattern sequencer with mode and pause buttons
// Rev    : 1.0 - initial release
// ============================================================================
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int STEP_DIV   = DEFAULT_STEP_DIV,
  parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                btn_mode_n,
  input  logic                btn_pause_n,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                paused,
  output logic                step_tick
);

  localparam int PRESC_W = $clog2(STEP_DIV);
  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(STEP_DIV - 1);

  logic               w_mode_press;
  logic               w_pause_press;
  mode_e              w_mode_next;
  pattern_t           w_lit_step;
  pattern_t           w_lit_next;
  logic               w_dir_step;
  logic               w_dir_next;

  mode_e              r_mode;
  pattern_t           r_lit;
  pattern_t           r_led;
  logic               r_dir_up;
  logic               r_paused;
  logic               r_tick;
  logic [PRESC_W-1:0] r_presc;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_n     (btn_mode_n),
    .press     (w_mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_n     (btn_pause_n),
    .press     (w_pause_press)
  );

  assign w_mode_next = mode_e'(2'(r_mode + 2'd1));

  always_comb begin
    w_lit_step = r_lit;
    w_dir_step = r_dir_up;
    case (r_mode)
      MODE_SHIFT:  w_lit_step = {r_lit[NUM_LEDS-2:0], r_lit[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        if (r_dir_up) begin
          if (r_lit[NUM_LEDS-1]) begin
            w_dir_step = 1'b0;
            w_lit_step = r_lit >> 1;
          end else begin
            w_lit_step = r_lit << 1;
          end
        end else begin
          if (r_lit[0]) begin
            w_dir_step = 1'b1;
            w_lit_step = r_lit << 1;
          end else begin
            w_lit_step = r_lit >> 1;
          end
        end
      end
      MODE_FILL:   w_lit_step = (&r_lit) ? '0 : {r_lit[NUM_LEDS-2:0], 1'b1};
      MODE_BLINK:  w_lit_step = ~r_lit;
      default:     w_lit_step = r_lit;
    endcase
  end

  // A mode press reloads the pattern and discards any coincident step.
  always_comb begin
    w_lit_next = r_lit;
    w_dir_next = r_dir_up;
    if (w_mode_press) begin
      w_lit_next = init_pattern(w_mode_next);
      w_dir_next = 1'b1;
    end else if (r_tick) begin
      w_lit_next = w_lit_step;
      w_dir_next = w_dir_step;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode   <= MODE_SHIFT;
      r_lit    <= INIT_SHIFT;
      r_led    <= ~INIT_SHIFT;
      r_dir_up <= 1'b1;
      r_paused <= 1'b0;
      r_tick   <= 1'b0;
      r_presc  <= '0;
    end else begin
      r_lit    <= w_lit_next;
      r_led    <= ~w_lit_next;
      r_dir_up <= w_dir_next;
      r_paused <= r_paused ^ w_pause_press;
      if (w_mode_press) begin
        r_mode  <= w_mode_next;
        r_presc <= '0;
        r_tick  <= 1'b0;
      end else if (r_paused) begin
        r_tick  <= 1'b0;
      end else begin
        r_tick  <= (r_presc == c_presc_last);
        r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
      end
    end
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign paused    = r_paused;
  assign step_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_led_mode_sequencer
// Brief  : Self-checking bench with a pattern-table reference model
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int STEP_DIV = 4;
  localparam int DEB      = 3;

  logic       sys_clk     = 1'b0;
  logic       sys_rst_n   = 1'b0;
  logic       btn_mode_n  = 1'b1;
  logic       btn_pause_n = 1'b1;
  logic [5:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  led_mode_sequencer #(.STEP_DIV(STEP_DIV), .DEB_CYCLES(DEB)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .btn_mode_n  (btn_mode_n),
    .btn_pause_n (btn_pause_n),
    .led         (led),
    .mode        (mode),
    .paused      (paused),
    .step_tick   (step_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lit is a function of (mode, steps taken since reload).
  int m_mode, m_idx, m_presc;
  bit m_paused, m_tick;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_acc[2];
  bit m_press[2];
  bit m_hist[2][DEB];

  function automatic logic [5:0] pattern(input int md, input int idx);
    int k;
    case (md)
      0: return 6'd1 << (idx % 6);
      1: begin k = idx % 10; return 6'd1 << ((k <= 5) ? k : 10 - k); end
      2: begin k = idx % 7;  return 6'((1 << k) - 1); end
      default: return (idx % 2 == 1) ? 6'h3f : 6'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_presc = 0; m_paused = 0; m_tick = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1; m_s2[b] = 1; m_acc[b] = 1; m_press[b] = 0;
      for (int i = 0; i < DEB; i++) m_hist[b][i] = 1;
    end
  endtask

  task automatic model_step();
    bit raw[2];
    bit new_press[2];
    bit all_diff;
    raw[0] = btn_mode_n;
    raw[1] = btn_pause_n;
    for (int b = 0; b < 2; b++) begin
      for (int i = DEB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = m_s2[b];
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_acc[b]) all_diff = 0;
      new_press[b] = 0;
      if (all_diff) begin
        m_acc[b] = m_s2[b];
        new_press[b] = (m_s2[b] == 0);
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    if (m_press[0]) begin
      m_mode = (m_mode + 1) % 4; m_idx = 0; m_presc = 0; m_tick = 0;
    end else begin
      if (m_tick) m_idx++;
      if (m_paused) m_tick = 0;
      else begin
        m_tick  = (m_presc == STEP_DIV - 1);
        m_presc = (m_presc + 1) % STEP_DIV;
      end
    end
    if (m_press[1]) m_paused = !m_paused;
    m_press[0] = new_press[0];
    m_press[1] = new_press[1];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [5:0] exp_led;
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        exp_led = ~pattern(m_mode, m_idx);
        check("led",       led,       exp_led);
        check("mode",      mode,      m_mode[1:0]);
        check("paused",    paused,    m_paused);
        check("step_tick", step_tick, m_tick);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_btn(input int which, input bit v);
    if (which == 0) btn_mode_n = v;
    else btn_pause_n = v;
  endtask

  task automatic press_btn(input int which);
    set_btn(which, 0);
    cycles(8);
    set_btn(which, 1);
    cycles(8);
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    while (step_tick !== 1'b1 && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    if (step_tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] shift_seq[7];
    logic [5:0] held_led;
    int w, ticks;
    shift_seq = '{6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b111110, 6'b111101};

    cycles(3);
    check("rst_led",    led,       6'b111110);
    check("rst_mode",   mode,      2'd0);
    check("rst_paused", paused,    1'b0);
    check("rst_tick",   step_tick, 1'b0);
    sys_rst_n = 1'b1;
    chk_en = 1'b1;

    // Shift mode stepping and tick spacing
    for (int k = 0; k < 7; k++) begin
      wait_tick(w);
      if (k > 0) check("tick_gap", w, 3);
      @(negedge sys_clk);
      check("shift_led", led, shift_seq[k]);
    end

    // Short glitch rejected, long press accepted with fixed latency
    btn_mode_n = 0; cycles(2); btn_mode_n = 1; cycles(10);
    check("glitch_mode", mode, 2'd0);
    btn_mode_n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge sys_clk);
      if (i == 5) check("press_lat_before", mode, 2'd0);
      if (i == 6) begin
        check("press_lat_mode", mode, 2'd1);
        check("press_lat_led",  led,  6'b111110);
      end
    end
    cycles(4); btn_mode_n = 1; cycles(10);
    check("release_no_press", mode, 2'd1);

    // Bounce, then blink
    cycles(4 * 12 + 4);
    press_btn(0);
    btn_mode_n = 0; cycles(6);
    check("blink_mode", mode, 2'd3);
    check("blink_led",  led,  6'b111111);
    cycles(2); btn_mode_n = 1; cycles(8);
    cycles(20);

    // Fill, pause freeze, resume
    press_btn(0); press_btn(0); press_btn(0);
    cycles(10);
    btn_pause_n = 0; cycles(6);
    check("pause_set", paused, 1'b1);
    btn_pause_n = 1;
    held_led = led;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (step_tick === 1'b1) ticks++;
    end
    check("pause_ticks", ticks, 0);
    check("pause_led_held", led, held_led);
    press_btn(1);
    check("pause_clear", paused, 1'b0);
    cycles(30);

    // Presses at every phase relative to step_tick, with and without pause
    for (int off = 0; off < 4; off++) begin
      for (int both = 0; both < 2; both++) begin
        wait_tick(w);
        cycles(off);
        btn_mode_n = 0;
        if (both == 1) btn_pause_n = 0;
        cycles(8);
        btn_mode_n = 1; btn_pause_n = 1;
        cycles(8);
        if (both == 1) press_btn(1);
      end
    end

    // Random button activity
    for (int r = 0; r < 300; r++) begin
      btn_mode_n  = ($urandom_range(0, 3) != 0);
      btn_pause_n = ($urandom_range(0, 3) != 0);
      cycles($urandom_range(1, 12));
    end
    btn_mode_n = 1; btn_pause_n = 1;
    cycles(20);

    // Async reset while in fill, paused and mid-debounce
    for (int i = 0; i < 4; i++) if (m_mode != 2) press_btn(0);
    if (!m_paused) press_btn(1);
    check("pre_rst_mode",   mode,   2'd2);
    check("pre_rst_paused", paused, 1'b1);
    btn_mode_n = 0;
    cycles(3);
    @(posedge sys_clk);
    #2 sys_rst_n = 0;
    #1;
    check("arst_led",    led,       6'b111110);
    check("arst_mode",   mode,      2'd0);
    check("arst_paused", paused,    1'b0);
    check("arst_tick",   step_tick, 1'b0);
    cycles(2);
    sys_rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge sys_clk);
      if (i == 5) check("post_rst_before", mode, 2'd0);
      if (i == 6) check("post_rst_press",  mode, 2'd1);
    end
    btn_mode_n = 1;
    cycles(10);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
